// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NREG 32-bit read/write registers with byte-lane strobes.
// Independent write (W_COLLECT/W_RESP) and read (R_IDLE/R_DATA) state machines.
module axi_lite_slave_regs #(
    parameter int unsigned NREG = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID,
    input  logic [31:0]       AWADDR,
    output logic              AWREADY,
    input  logic              WVALID,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    output logic              WREADY,
    output logic              BVALID,
    output logic [1:0]        BRESP,
    input  logic              BREADY,
    input  logic              ARVALID,
    input  logic [31:0]       ARADDR,
    output logic              ARREADY,
    output logic              RVALID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    input  logic              RREADY,
    output logic [32*NREG-1:0] regs
);

    localparam int unsigned IDXW   = $clog2(NREG);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA}    rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic            rst_done;
    logic            aw_full, w_full;
    logic [31:2]     aw_addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            commit;
    logic            aw_hs, w_hs, ar_hs;
    logic [IDXW-1:0] wr_idx, rd_idx;
    logic            wr_in_range, rd_in_range;
    logic [31:0]     regs_q [NREG];

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    assign wr_idx      = aw_addr_q[IDXW+1:2];
    assign wr_in_range = (aw_addr_q[31:IDXW+2] == '0);
    assign rd_idx      = ARADDR[IDXW+1:2];
    assign rd_in_range = (ARADDR[31:IDXW+2] == '0);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            wstate <= W_COLLECT;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
        end
    end

    // READY outputs are gated by rst_done so they stay low until the first edge after reset.
    always_comb begin
        wstate_nxt = wstate;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        commit     = 1'b0;
        case (wstate)
            W_COLLECT: begin
                AWREADY = rst_done && !aw_full;
                WREADY  = rst_done && !w_full;
                if (aw_full && w_full) begin
                    commit     = 1'b1;
                    wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) wstate_nxt = W_COLLECT;
            end
            default: wstate_nxt = W_COLLECT;
        endcase
    end

    always_comb begin
        rstate_nxt = rstate;
        ARREADY    = 1'b0;
        case (rstate)
            R_IDLE: begin
                ARREADY = rst_done;
                if (ar_hs) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (RVALID && RREADY) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            rst_done  <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            BVALID    <= 1'b0;
            BRESP     <= '0;
            for (int unsigned k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            rst_done <= 1'b1;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_in_range ? OKAY : SLVERR;
                if (wr_in_range) begin
                    for (int unsigned b = 0; b < 4; b++)
                        if (wstrb_q[b]) regs_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= AWADDR[31:2];
                end
                if (w_hs) begin
                    w_full  <= 1'b1;
                    wdata_q <= WDATA;
                    wstrb_q <= WSTRB;
                end
                if (BVALID && BREADY) BVALID <= 1'b0;
            end
        end
    end

    // Read data is sampled from regs_q before any same-edge commit lands.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= '0;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_in_range ? regs_q[rd_idx] : '0;
            RRESP  <= rd_in_range ? OKAY : SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_regs_out
        assign regs[32*k +: 32] = regs_q[k];
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (NREG=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_lite_slave_regs;

    localparam int unsigned NREG = 4;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b0;
    logic              AWVALID = 1'b0;
    logic [31:0]       AWADDR = '0;
    logic              AWREADY;
    logic              WVALID = 1'b0;
    logic [31:0]       WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WREADY;
    logic              BVALID;
    logic [1:0]        BRESP;
    logic              BREADY = 1'b0;
    logic              ARVALID = 1'b0;
    logic [31:0]       ARADDR = '0;
    logic              ARREADY;
    logic              RVALID;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RREADY = 1'b0;
    logic [32*NREG-1:0] regs;

    int checks = 0;
    int errors = 0;

    axi_lite_slave_regs #(.NREG(NREG)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
        .regs(regs)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_hs, w_hs, got;
        AWVALID = 1'b1; AWADDR = addr;
        WVALID  = 1'b1; WDATA  = data; WSTRB = strb;
        for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
        end
        chk("wr_addr_data_accept", {126'd0, AWVALID, WVALID}, 128'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 20 && !BVALID; i++) @(negedge ACLK);
        got = BVALID;
        chk("wr_bvalid_timeout", {127'd0, got}, 128'd1);
        resp = BRESP;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic ar_hs, got;
        ARVALID = 1'b1; ARADDR = addr;
        for (int i = 0; i < 20 && ARVALID; i++) begin
            ar_hs = ARREADY;
            @(negedge ACLK);
            if (ar_hs) ARVALID = 1'b0;
        end
        chk("rd_addr_accept", {127'd0, ARVALID}, 128'd0);
        ARVALID = 1'b0;
        for (int i = 0; i < 20 && !RVALID; i++) @(negedge ACLK);
        got = RVALID;
        chk("rd_rvalid_timeout", {127'd0, got}, 128'd1);
        data = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        // Reset state
        repeat (2) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready",  WREADY,  0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid",  BVALID,  0);
        chk("rst_rvalid",  RVALID,  0);
        chk("rst_rdata",   RDATA,   0);
        chk("rst_regs",    regs,    0);
        ARESET = 1'b1;
        #1 chk("ready_low_before_edge", AWREADY, 0);
        @(negedge ACLK);
        chk("awready_after_rst", AWREADY, 1);
        chk("wready_after_rst",  WREADY,  1);
        chk("arready_after_rst", ARREADY, 1);

        // AW and W together to 0x4
        AWVALID = 1'b1; AWADDR = 32'h4;
        WVALID  = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        @(negedge ACLK);
        chk("same_awready_buffered", AWREADY, 0);
        chk("same_wready_buffered",  WREADY,  0);
        chk("same_bvalid_early",     BVALID,  0);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        chk("same_bvalid", BVALID, 1);
        chk("same_bresp",  BRESP,  0);
        chk("same_reg1",   regs[63:32], 32'hDEADBEEF);
        chk("wresp_awready_low", AWREADY, 0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_hs_bvalid_clear", BVALID, 0);
        chk("b_hs_awready_back", AWREADY, 1);

        // W first, AW three cycles later, partial strobe
        axi_write(32'h8, 32'hAAAAAAAA, 4'hF, resp);
        chk("reg2_init_resp", resp, 0);
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'h3;
        @(negedge ACLK);
        chk("wfirst_wready_low", WREADY, 0);
        chk("wfirst_awready",    AWREADY, 1);
        WVALID = 1'b0;
        @(negedge ACLK);
        chk("wfirst_no_bvalid", BVALID, 0);
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h8;
        @(negedge ACLK);
        chk("wfirst_bvalid_not_yet", BVALID, 0);
        AWVALID = 1'b0;
        @(negedge ACLK);
        chk("wfirst_bvalid", BVALID, 1);
        chk("wfirst_bresp",  BRESP, 0);
        chk("wfirst_reg2",   regs[95:64], 32'hAAAA3344);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // Read 0x4 with RREADY held low
        ARVALID = 1'b1; ARADDR = 32'h4;
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rhold_rvalid",  RVALID,  1);
            chk("rhold_rdata",   RDATA,   32'hDEADBEEF);
            chk("rhold_rresp",   RRESP,   0);
            chk("rhold_arready", ARREADY, 0);
            if (i < 4) @(negedge ACLK);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        chk("rhs_rvalid_clear", RVALID,  0);
        chk("rhs_arready_back", ARREADY, 1);

        // Out-of-range write and read, address LSBs ignored, byte strobes
        axi_write(32'h10, 32'h12345678, 4'hF, resp);
        chk("oor_bresp", resp, 2'b10);
        chk("oor_regs_unchanged", regs, {32'h0, 32'hAAAA3344, 32'hDEADBEEF, 32'h0});
        axi_read(32'h10, data, resp);
        chk("oor_rdata", data, 0);
        chk("oor_rresp", resp, 2'b10);
        axi_read(32'h9, data, resp);
        chk("lsb_ignored_rdata", data, 32'hAAAA3344);
        chk("lsb_ignored_rresp", resp, 0);
        axi_write(32'h0, 32'hCAFEF00D, 4'b0110, resp);
        chk("strb_mid_resp", resp, 0);
        chk("strb_mid_reg0", regs[31:0], 32'h00FEF000);
        axi_read(32'hC, data, resp);
        chk("last_reg_rdata", data, 0);

        // BREADY held low with a second write pending
        AWVALID = 1'b1; AWADDR = 32'hC;
        WVALID  = 1'b1; WDATA = 32'h01020304; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        chk("bp_first_bvalid", BVALID, 1);
        AWVALID = 1'b1; AWADDR = 32'hC;
        WVALID  = 1'b1; WDATA = 32'h55667788; WSTRB = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("bp_awready_low", AWREADY, 0);
            chk("bp_bvalid_held", BVALID, 1);
            chk("bp_reg3_first",  regs[127:96], 32'h01020304);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bp_bvalid_clear", BVALID,  0);
        chk("bp_awready_back", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("bp_second_buffered", AWREADY, 0);
        @(negedge ACLK);
        chk("bp_second_bvalid", BVALID, 1);
        chk("bp_second_bresp",  BRESP, 0);
        chk("bp_second_reg3",   regs[127:96], 32'h55667788);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // AR handshake on the same edge as a commit to the same register
        AWVALID = 1'b1; AWADDR = 32'h0;
        WVALID  = 1'b1; WDATA = 32'h11111111; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'h0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("raw_rdata_prewrite", RDATA, 32'h00FEF000);
        chk("raw_reg0_written",   regs[31:0], 32'h11111111);
        chk("raw_bvalid",         BVALID, 1);
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;

        // Reset while BVALID and RVALID are both high
        AWVALID = 1'b1; AWADDR = 32'h4;
        WVALID  = 1'b1; WDATA = 32'h99999999; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h8;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        chk("pre_rst_bvalid", BVALID, 1);
        chk("pre_rst_rvalid", RVALID, 1);
        #2 ARESET = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, 0);
        chk("mid_rst_regs", regs, 0);
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_regs", regs, 0);
        axi_write(32'h4, 32'h0BADF00D, 4'hF, resp);
        chk("post_rst_bresp", resp, 0);
        axi_read(32'h4, data, resp);
        chk("post_rst_rdata", data, 32'h0BADF00D);
        chk("post_rst_rresp", resp, 0);
        axi_read(32'h8, data, resp);
        chk("post_rst_reg2_zero", data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter NREG, default 4, number of 32-bit registers; power of two, 2..16.
REQ-002 SHALL have port ACLK  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port ARESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port AWVALID  input  1  write-address valid.
REQ-005 SHALL have port AWADDR  input  32  write byte address.
REQ-006 SHALL have port AWREADY  output  1  write-address ready.
REQ-007 SHALL have port WVALID  input  1  write-data valid.
REQ-008 SHALL have port WDATA  input  32  write data.
REQ-009 SHALL have port WSTRB  input  4  byte-lane enables; bit i covers WDATA[8i+7:8i].
REQ-010 SHALL have port WREADY  output  1  write-data ready.
REQ-011 SHALL have port BVALID  output  1  write-response valid.
REQ-012 SHALL have port BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 SHALL have port BREADY  input  1  write-response ready.
REQ-014 SHALL have port ARVALID  input  1  read-address valid.
REQ-015 SHALL have port ARADDR  input  32  read byte address.
REQ-016 SHALL have port ARREADY  output  1  read-address ready.
REQ-017 SHALL have port RVALID  output  1  read-data valid.
REQ-018 SHALL have port RDATA  output  32  read data.
REQ-019 SHALL have port RRESP  output  2  read response: OKAY or SLVERR.
REQ-020 SHALL have port RREADY  input  1  read-data ready.
REQ-021 SHALL have port regs  output  32*NREG  live register contents; reg k is bits [32k+31:32k].

Function
REQ-022 SHALL decode the register index from addr[log2(NREG)+1:2], ignore addr[1:0], and treat any address >= NREG*4 as out of range.
REQ-023 SHALL implement the write path as a state machine with states W_COLLECT and W_RESP.
REQ-024 In W_COLLECT, SHALL drive AWREADY=1 while no address is buffered and WREADY=1 while no data is buffered.
REQ-025 SHALL capture AWADDR on the AWVALID&&AWREADY edge and WDATA/WSTRB on the WVALID&&WREADY edge, in either order or on the same edge.
REQ-026 On the edge after both are buffered, SHALL update the addressed register only on lanes with WSTRB=1, set BVALID=1 and BRESP=OKAY, and enter W_RESP.
REQ-027 If the address is out of range, SHALL leave all registers unchanged, set BVALID=1 and BRESP=SLVERR.
REQ-028 In W_RESP, SHALL hold AWREADY=WREADY=0 and hold BVALID/BRESP stable until BVALID&&BREADY, then clear BVALID and return to W_COLLECT with both buffers empty.
REQ-029 SHALL implement the read path as a state machine with states R_IDLE and R_DATA, independent of the write path.
REQ-030 In R_IDLE, SHALL drive ARREADY=1; on ARVALID&&ARREADY, SHALL register RDATA from the addressed register, set RRESP, set RVALID=1 and enter R_DATA, giving 1-cycle latency.
REQ-031 For an out-of-range read, SHALL return RDATA=0 with RRESP=SLVERR.
REQ-032 In R_DATA, SHALL drive ARREADY=0 and hold RVALID/RDATA/RRESP stable until RVALID&&RREADY, then clear RVALID and return to R_IDLE.
REQ-033 If an AR handshake and a register write commit occur on the same edge to the same register, SHALL return the pre-write value.
REQ-034 SHALL never make a VALID output depend combinationally on a READY input, and SHALL never drop an asserted VALID before its handshake.
REQ-035 SHALL accept AWVALID/WVALID/ARVALID arriving while the matching READY is already high, completing the handshake on that same edge.

Reset
REQ-036 While ARESET=0, SHALL force AWREADY, WREADY, BVALID, ARREADY, RVALID to 0, BRESP, RRESP and RDATA to 0, all registers to 0, states to W_COLLECT/R_IDLE, and both buffers to empty.
REQ-037 READY outputs SHALL rise on the first clock edge after ARESET deasserts.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no partial register update.

Verification
REQ-039 AW and W on the same cycle to 0x4, data 0xDEADBEEF, WSTRB=0xF -> BVALID next cycle with BRESP=00; regs[63:32]=0xDEADBEEF.
REQ-040 W first (0x11223344, WSTRB=0x3), then AW 0x8 three cycles later, reg2 previously 0xAAAAAAAA -> reg2=0xAAAA3344; BVALID one cycle after the AW handshake.
REQ-041 Write then read 0x4 with RREADY held low 5 cycles -> RVALID=1 with RDATA=0xDEADBEEF stable all 5 cycles; ARREADY=0 until RREADY handshake.
REQ-042 Write 0x10 with NREG=4 -> BRESP=10 and regs unchanged; read 0x10 -> RDATA=0, RRESP=10.
REQ-043 BREADY held low 4 cycles after BVALID, with a second AWVALID pending -> AWREADY=0 until the B handshake, then the second write completes normally.
REQ-044 ARESET pulsed low while BVALID=1 and RVALID=1 -> all outputs 0 immediately, all regs 0; a fresh write and read afterwards complete normally.
